alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8..64, power of two).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), number of shift-amount bits taken from B_i.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start_i  input  1  request; accepted only on a rising edge while Busy_o=0.
REQ-006 SHALL have port ALU_Operation_i  input  4  operation code, sampled on accept.
REQ-007 SHALL have port A_i  input  WIDTH  signed operand A, sampled on accept.
REQ-008 SHALL have port B_i  input  WIDTH  signed operand B, sampled on accept.
REQ-009 SHALL have port Busy_o  output  1  operation in flight; new Start_i ignored.
REQ-010 SHALL have port Done_o  output  1  one-cycle pulse; ALU_Result_o valid and new.
REQ-011 SHALL have port Zero_o  output  1  1 when the registered ALU_Result_o equals 0.
REQ-012 SHALL have port ALU_Result_o  output  WIDTH  registered result; holds until the next Done_o.

Function
REQ-013 SHALL decode single-pass ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL (logical), 0111 LUI (B<<12).
REQ-014 SHALL decode iterative ops: 1000 MUL (low WIDTH bits), 1001 MULH (signed x signed, high WIDTH bits), 1010 DIV, 1011 DIVU, 1100 REM, 1101 REMU; codes 1110/1111 SHALL yield result 0 via the single-pass path.
REQ-015 SHALL use only B[SHAMT_W-1:0] as the shift amount for SLL/SRL.
REQ-016 SHALL implement FSM states IDLE, CALC, FIX; reset state IDLE.
REQ-017 On accept of a single-pass op (edge E): stay IDLE, load ALU_Result_o at E, pulse Done_o for the cycle after E (latency 1); Busy_o stays 0.
REQ-018 On accept of an iterative op (edge E): go to CALC; Busy_o=1 from E.
REQ-019 CALC SHALL run exactly WIDTH cycles, one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, on operand magnitudes.
REQ-020 FIX SHALL last one cycle, apply sign correction, load ALU_Result_o at edge E+WIDTH+1, and return to IDLE; Done_o=1 and Busy_o=0 in the following cycle (latency WIDTH+1).
REQ-021 Quotient sign SHALL be sign(A) XOR sign(B); remainder sign SHALL follow A (truncating division).
REQ-022 Divide by zero: DIV/DIVU SHALL return all ones; REM/REMU SHALL return A; latency unchanged.
REQ-023 Signed overflow (A = most-negative, B = -1): DIV SHALL return A; REM SHALL return 0.
REQ-024 A Start_i asserted on the Done_o cycle SHALL be accepted (back-to-back issue).
REQ-025 Start_i while Busy_o=1 SHALL be ignored without affecting the in-flight operation.
REQ-026 Input changes after accept SHALL NOT affect the result.
REQ-027 Zero_o SHALL be combinationally derived from the registered ALU_Result_o.

Reset
REQ-028 Reset asserted SHALL immediately force state IDLE, Busy_o=0, Done_o=0, ALU_Result_o=0, Zero_o=1, and clear all iteration counters and operand registers.
REQ-029 Reset mid-CALC or mid-FIX SHALL abort the operation with no Done_o pulse; the first accept after release SHALL behave as from power-up.

Verification
REQ-030 ADD A=7, B=-3, Start_i for 1 cycle -> next cycle Done_o=1, ALU_Result_o=4, Zero_o=0, Busy_o=0 throughout.
REQ-031 MUL A=-6, B=7 (WIDTH=32) -> Busy_o=1 for 33 cycles, then Done_o=1 with result 0xFFFFFFD6; MULH A=0x80000000, B=0x80000000 -> 0x40000000.
REQ-032 DIV A=-7, B=2 -> -3; REM -> -1; DIVU A=7, B=0 -> 0xFFFFFFFF; REMU A=7, B=0 -> 7; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0.
REQ-033 Start DIVU A=100, B=7, pulse Start_i with ADD during Busy_o -> ignored, Done_o gives 14; Start SUB 5-5 on that Done_o cycle -> next cycle result 0, Zero_o=1.
REQ-034 Assert reset at CALC cycle 10 of a MUL -> outputs cleared immediately, no Done_o; after release SLL A=1, B=0x21 -> result 2.

Source files
------------

// File: rtl/alu_muldiv.sv
// Multi-cycle ALU: single-pass logic/arith ops with one-cycle latency, plus
// iterative shift-add multiply and restoring divide (WIDTH+1 cycle latency).
module alu_muldiv #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [3:0]       ALU_Operation_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Zero_o,
    output logic [WIDTH-1:0] ALU_Result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_LUI  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_MULH = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REM  = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;

    logic               w_accept;
    logic               w_iter;
    logic               w_signed;
    logic               w_is_mul_in;
    logic               w_is_mul_reg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [WIDTH:0]     w_dshift;
    logic               w_dge;
    logic [WIDTH-1:0]   w_ddiff;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_fix;

    assign w_accept     = Start_i && !r_busy;
    assign w_iter       = ALU_Operation_i[3] && (ALU_Operation_i[2:1] != 2'b11);
    assign w_signed     = (ALU_Operation_i == OP_MUL) || (ALU_Operation_i == OP_MULH) ||
                          (ALU_Operation_i == OP_DIV) || (ALU_Operation_i == OP_REM);
    assign w_is_mul_in  = (ALU_Operation_i[3:1] == 3'b100);
    assign w_is_mul_reg = (r_op[3:1] == 3'b100);
    // The most-negative value's magnitude still fits as an unsigned WIDTH-bit number.
    assign w_a_mag      = (w_signed && A_i[WIDTH-1]) ? -A_i : A_i;
    assign w_b_mag      = (w_signed && B_i[WIDTH-1]) ? -B_i : B_i;

    always_comb begin
        w_alu = '0;
        case (ALU_Operation_i)
            OP_ADD:  w_alu = A_i + B_i;
            OP_SUB:  w_alu = A_i - B_i;
            OP_AND:  w_alu = A_i & B_i;
            OP_OR:   w_alu = A_i | B_i;
            OP_XOR:  w_alu = A_i ^ B_i;
            OP_SLL:  w_alu = A_i << B_i[SHAMT_W-1:0];
            OP_SRL:  w_alu = A_i >> B_i[SHAMT_W-1:0];
            OP_LUI:  w_alu = B_i << 12;
            default: w_alu = '0;
        endcase
    end

    // Multiply step: {hi,lo} shifts right, multiplier bits consumed from lo[0].
    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mul_hi = w_msum[WIDTH:1];
    assign w_mul_lo = {w_msum[0], r_lo[WIDTH-1:1]};

    // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_mcand});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_mcand;
    assign w_div_hi = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_dge};

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quot_s = r_neg_q ? -r_lo : r_lo;
    assign w_rem_s  = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        w_fix = '0;
        case (r_op)
            OP_MUL:  w_fix = w_prod_s[WIDTH-1:0];
            OP_MULH: w_fix = w_prod_s[2*WIDTH-1:WIDTH];
            OP_DIV:  w_fix = r_div0 ? '1 : w_quot_s;
            OP_DIVU: w_fix = r_div0 ? '1 : r_lo;
            OP_REM:  w_fix = w_rem_s;
            OP_REMU: w_fix = r_hi;
            default: w_fix = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mcand  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_op    <= ALU_Operation_i;
                            r_cnt   <= '0;
                            r_hi    <= '0;
                            r_lo    <= w_is_mul_in ? w_b_mag : w_a_mag;
                            r_mcand <= w_is_mul_in ? w_a_mag : w_b_mag;
                            r_neg_q <= w_signed && (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
                            r_neg_r <= w_signed && A_i[WIDTH-1];
                            r_div0  <= (B_i == '0);
                        end else begin
                            r_result <= w_alu;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_hi  <= w_is_mul_reg ? w_mul_hi : w_div_hi;
                    r_lo  <= w_is_mul_reg ? w_mul_lo : w_div_lo;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy_o       = r_busy;
    assign Done_o       = r_done;
    assign ALU_Result_o = r_result;
    assign Zero_o       = (r_result == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops
// against an arithmetic reference model, back-to-back/ignored-start and reset-abort sequences.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         zero;
    logic [W-1:0] result;

    int vectors     = 0;
    int miscompares = 0;
    int checks      = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[19];

    alu_muldiv #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .Start_i        (start),
        .ALU_Operation_i(op),
        .A_i            (a),
        .B_i            (b),
        .Busy_o         (busy),
        .Done_o         (done),
        .Zero_o         (zero),
        .ALU_Result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [3:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx;
        longint sy;
        longint p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return x << y[4:0];
            4'd6:  return x >> y[4:0];
            4'd7:  return y << 12;
            4'd8:  begin p = sx * sy; return p[31:0]; end
            4'd9:  begin p = sx * sy; return p[63:32]; end
            4'd10: begin
                if (y == 0) return '1;
                p = sx / sy;
                return p[31:0];
            end
            4'd11: return (y == 0) ? '1 : x / y;
            4'd12: begin
                if (y == 0) return x;
                p = sx % sy;
                return p[31:0];
            end
            4'd13: return (y == 0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    // Issue one op, scramble inputs after accept, and check result, Zero_o, latency, busy span.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp, input string tag);
        int  off;
        int  busy_cnt;
        int  exp_off;
        bit  seen;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        off = 0; busy_cnt = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_cnt++;
            if (done) begin seen = 1; break; end
            @(posedge clk);
            #1;
            off++;
        end
        exp_off = (o[3] && o[2:1] != 2'b11) ? W + 1 : 0;
        vectors++;
        if (!seen) begin
            checks++;
            miscompares++;
            $display("FAIL %s timeout: no Done_o within 100 cycles, required %0d", tag, exp_off);
        end else begin
            check({tag, " result"}, 64'(result), 64'(exp));
            check({tag, " zero"}, 64'(zero), 64'(exp == '0));
            check({tag, " latency"}, 64'(off), 64'(exp_off));
            check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_off));
            @(posedge clk);
            #1;
            check({tag, " done_pulse"}, 64'(done), 64'd0);
        end
        $display("txn %s op=%0d a=%h b=%h result=%h expected=%h cycles=%0d", tag, o, x, y,
                 result, exp, off);
    endtask

    initial begin
        int  off;
        bit  seen;
        int  sel;
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        tbl[0]  = '{4'd0,  32'd7,        -32'sd3,      32'd4};
        tbl[1]  = '{4'd8,  -32'sd6,      32'd7,        32'hFFFFFFD6};
        tbl[2]  = '{4'd9,  32'h80000000, 32'h80000000, 32'h40000000};
        tbl[3]  = '{4'd10, -32'sd7,      32'd2,        32'hFFFFFFFD};
        tbl[4]  = '{4'd12, -32'sd7,      32'd2,        32'hFFFFFFFF};
        tbl[5]  = '{4'd11, 32'd7,        32'd0,        32'hFFFFFFFF};
        tbl[6]  = '{4'd13, 32'd7,        32'd0,        32'd7};
        tbl[7]  = '{4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[8]  = '{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        tbl[9]  = '{4'd10, -32'sd7,      32'd0,        32'hFFFFFFFF};
        tbl[10] = '{4'd12, -32'sd7,      32'd0,        32'hFFFFFFF9};
        tbl[11] = '{4'd5,  32'd1,        32'h21,       32'd2};
        tbl[12] = '{4'd6,  32'h80000000, 32'd31,       32'd1};
        tbl[13] = '{4'd7,  32'd0,        32'h12345,    32'h12345000};
        tbl[14] = '{4'd14, 32'h1234,     32'h5678,     32'd0};
        tbl[15] = '{4'd1,  32'd5,        32'd5,        32'd0};
        tbl[16] = '{4'd9,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        tbl[17] = '{4'd13, 32'd100,      32'd7,        32'd2};
        tbl[18] = '{4'd4,  32'h0000F0F0, 32'h00000FF0, 32'h0000FF00};

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset zero", 64'(zero), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("table%0d", i));
        end

        // Reset in the middle of a multiply: immediate clear, no Done_o afterwards.
        @(negedge clk);
        start = 1'b1; op = 4'd8; a = -32'sd6; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort zero", 64'(zero), 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check("abort no_done", 64'(seen), 64'd0);
        $display("txn abort MUL mid-CALC busy=%0d done=%0d result=%h", busy, done, result);
        run_op(4'd5, 32'd1, 32'h21, 32'd2, "post_reset_sll");

        for (int n = 0; n < 150; n++) begin
            ro  = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin ra = 32'h80000000; rb = '1; end
            else if (sel == 2) rb = W'($urandom_range(1, 15));
            run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rand%0d", n));
        end

        // DIVU with an ignored ADD start while busy, then SUB issued on the Done_o cycle.
        @(negedge clk);
        start = 1'b1; op = 4'd11; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = '0; a = '0; b = '0;
        off = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin seen = 1; break; end
            if (off == 5) begin start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; end
            else start = 1'b0;
            @(posedge clk);
            #1;
            off++;
        end
        vectors++;
        if (!seen) begin
            checks++;
            miscompares++;
            $display("FAIL b2b_divu timeout: no Done_o within 100 cycles, required %0d", W + 1);
        end else begin
            check("b2b_divu result", 64'(result), 64'd14);
            check("b2b_divu latency", 64'(off), 64'(W + 1));
            start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
            vectors++;
            check("b2b_sub done", 64'(done), 64'd1);
            check("b2b_sub result", 64'(result), 64'd0);
            check("b2b_sub zero", 64'(zero), 64'd1);
        end
        $display("txn b2b DIVU 100/7 then SUB 5-5 result=%h zero=%0d", result, zero);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
